// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-domain front end of an async FIFO (push handshake, write pointers, full/level/overflow)
module fifo_write_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int ALMOST_FULL_TH = 28
) (
    input  logic                  clk1,
    input  logic                  resetw,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    input  logic                  clear_overflow,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] wd,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] wbin, wbin_next, wgray_next, rq, rbin_sync, level_next;
    logic accept;
    assign push_ready = resetw & ~full;
    assign accept     = push_valid & push_ready;
    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq         = sync_q[SYNC_STAGES-1];
    assign level_next = wbin_next - rbin_sync;
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++) rbin_sync[i] = ^(rq >> i);
    end
    always_ff @(posedge clk1 or negedge resetw) begin
        if (!resetw) begin
            sync_q      <= '0;
            wbin        <= '0;
            wptr        <= '0;
            wptr_gray   <= '0;
            wd          <= '0;
            writeEnable <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
            overflow    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rptr_gray_async};
            writeEnable <= accept;
            wptr        <= accept ? wbin : wptr;
            wd          <= accept ? push_data : wd;
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            // full when the write pointer sits a whole lap ahead of the synchronised read pointer
            full        <= wgray_next == {~rq[PW-1:PW-2], rq[PW-3:0]};
            fill_level  <= level_next;
            almost_full <= level_next >= PW'(ALMOST_FULL_TH);
            overflow    <= (push_valid & full) | (overflow & ~clear_overflow);
        end
    end
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: scoreboard bench for fifo_write_ctrl
module tb_fifo_write_ctrl;
    logic        clk1 = 0;
    logic        resetw;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic [5:0]  rptr_gray_async;
    logic        clear_overflow;
    logic [5:0]  wptr;
    logic        writeEnable;
    logic [31:0] wd;
    logic [5:0]  wptr_gray;
    logic        full;
    logic        almost_full;
    logic [5:0]  fill_level;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] wb;
    logic [37:0] q[$];

    fifo_write_ctrl dut (
        .clk1(clk1), .resetw(resetw), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .rptr_gray_async(rptr_gray_async), .clear_overflow(clear_overflow),
        .wptr(wptr), .writeEnable(writeEnable), .wd(wd), .wptr_gray(wptr_gray), .full(full),
        .almost_full(almost_full), .fill_level(fill_level), .overflow(overflow)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [5:0] gray(input logic [5:0] x);
        return x ^ (x >> 1);
    endfunction

    always @(negedge clk1) begin
        if (resetw && writeEnable) begin
            logic [37:0] e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: wptr=%0d wd=%0d, required no write", wptr, wd);
            end else begin
                e = q.pop_front();
                if ({wptr, wd} !== e) begin
                    n_err++;
                    $display("FAIL wr_data: wptr=%0d wd=%0d, required wptr=%0d wd=%0d", wptr, wd, e[37:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    // called at a negedge; drives one cycle and returns at the following negedge
    task automatic cyc(input logic v, input logic [31:0] d, input logic clr);
        push_valid = v;
        push_data = d;
        clear_overflow = clr;
        if (v && push_ready) begin
            q.push_back({wb, d});
            wb++;
        end
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic test_reset;
        resetw = 0;
        push_valid = 0;
        push_data = 0;
        clear_overflow = 0;
        rptr_gray_async = 0;
        q.delete();
        wb = 0;
        @(negedge clk1);
        @(negedge clk1);
        n_vec++;
        if ({wptr, wptr_gray, wd, fill_level, writeEnable, full, almost_full, overflow, push_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_state: wptr=%0d gray=%0d wd=%0d lvl=%0d we=%b full=%b af=%b ovf=%b rdy=%b, required all 0",
                wptr, wptr_gray, wd, fill_level, writeEnable, full, almost_full, overflow, push_ready);
        end
        resetw = 1;
        @(negedge clk1);
        n_vec++;
        if (push_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: push_ready=%b, required 1", push_ready);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 32; i++) begin
            cyc(1, i, 0);
            n_vec++;
            if (full !== (i == 32)) begin
                n_err++;
                $display("FAIL fill_full[%0d]: full=%b, required %b", i, full, i == 32);
            end
        end
        n_vec++;
        if ({push_ready, fill_level, wptr_gray} !== {1'b0, 6'd32, 6'b110000}) begin
            n_err++;
            $display("FAIL fill_end: rdy=%b lvl=%0d gray=%b, required rdy=0 lvl=32 gray=110000", push_ready, fill_level, wptr_gray);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 99, 0);
            n_vec++;
            if ({writeEnable, wptr, overflow} !== {1'b0, 6'd31, 1'b1}) begin
                n_err++;
                $display("FAIL ovf_drop[%0d]: we=%b wptr=%0d ovf=%b, required we=0 wptr=31 ovf=1", i, writeEnable, wptr, overflow);
            end
        end
        cyc(1, 99, 1);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: overflow=%b, required 1", overflow);
        end
        cyc(0, 0, 1);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
        clear_overflow = 0;
    endtask

    task automatic test_drain;
        rptr_gray_async = 6'b000110;
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 0);
            n_vec++;
            if (full !== (k < 3)) begin
                n_err++;
                $display("FAIL drain_full[%0d]: full=%b, required %b", k, full, k < 3);
            end
        end
        n_vec++;
        if ({fill_level, almost_full, push_ready} !== {6'd28, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL drain_level: lvl=%0d af=%b rdy=%b, required lvl=28 af=1 rdy=1", fill_level, almost_full, push_ready);
        end
        cyc(1, 32'hCAFE, 0);
        n_vec++;
        if (fill_level !== 6'd29) begin
            n_err++;
            $display("FAIL drain_push_level: lvl=%0d, required 29", fill_level);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_stream;
        for (int n = 0; n < 66; n++) begin
            rptr_gray_async = gray(6'(n >= 8 ? n - 8 : 0));
            cyc(1, 32'h1000 + n, 0);
            n_vec++;
            if ({full, almost_full, push_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL stream[%0d]: full=%b af=%b rdy=%b, required 0 0 1", n, full, almost_full, push_ready);
            end
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < 5; n++) cyc(1, 32'h2000 + n, 0);
        push_valid = 1;
        push_data = 32'h2005;
        q.push_back({wb, push_data});
        wb++;
        @(posedge clk1);
        #2;
        resetw = 0;
        push_valid = 0;
        rptr_gray_async = 0;
        #1;
        n_vec++;
        if ({writeEnable, wptr, wptr_gray, wd, fill_level, full, almost_full, overflow, push_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: we=%b wptr=%0d gray=%0d wd=%0d lvl=%0d full=%b af=%b ovf=%b rdy=%b, required all 0",
                writeEnable, wptr, wptr_gray, wd, fill_level, full, almost_full, overflow, push_ready);
        end
        q.delete();
        wb = 0;
        @(negedge clk1);
        @(negedge clk1);
        resetw = 1;
        @(negedge clk1);
        cyc(1, 32'hABCD, 0);
        cyc(0, 0, 0);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_first_write: %0d writes missing, required 0", q.size());
        end
    endtask

    initial begin
        resetw = 0;
        push_valid = 0;
        push_data = 0;
        clear_overflow = 0;
        rptr_gray_async = 0;
        wb = 0;
        test_reset;
        test_fill;
        test_overflow;
        test_drain;
        test_reset;
        test_stream;
        test_reset_mid;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d writes missing, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
